// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: 1-entry hold register, LSB-first shift, framed by tx_en
// with GAP idle cycles between words. Define P2S_PARITY_EN to append an even-parity bit.
module p2s_tx #(
  parameter int BIT = 10,
  parameter int GAP = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [BIT-1:0] din,
  input  logic           din_valid,
  output logic           din_ready,
  output logic           dext,
  output logic           tx_en,
  output logic           tx_busy,
  output logic           p2s_done
);

`ifdef P2S_PARITY_EN
  localparam int NB = BIT + 1;
`else
  localparam int NB = BIT;
`endif
  localparam int CW = $clog2(BIT + 2);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CLAST = CW'(NB - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [GW-1:0]   gcnt;
  logic [BIT-1:0]  hold;
  logic [NB-1:0]   shreg;
  logic            load;

  function automatic logic [NB-1:0] frame(input logic [BIT-1:0] w);
`ifdef P2S_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  // hold is full exactly when din_ready is low
  assign load = !din_ready &&
                (state == S_IDLE || (state == S_GAP && gcnt == GLAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gcnt      <= '0;
      hold      <= '0;
      shreg     <= '0;
      din_ready <= 1'b1;
      dext      <= 1'b0;
      tx_en     <= 1'b0;
      tx_busy   <= 1'b0;
      p2s_done  <= 1'b0;
    end else begin
      p2s_done <= 1'b0;
      if (din_valid && din_ready) begin
        hold      <= din;
        din_ready <= 1'b0;
      end
      if (load) begin
        state     <= S_SHIFT;
        shreg     <= frame(hold);
        dext      <= hold[0];
        tx_en     <= 1'b1;
        tx_busy   <= 1'b1;
        cnt       <= '0;
        din_ready <= 1'b1;
      end else begin
        case (state)
          S_SHIFT: begin
            if (cnt == CLAST) begin
              state    <= S_GAP;
              tx_en    <= 1'b0;
              dext     <= 1'b0;
              p2s_done <= 1'b1;
              cnt      <= '0;
              gcnt     <= '0;
            end else begin
              cnt   <= cnt + 1'b1;
              shreg <= shreg >> 1;
              dext  <= shreg[1];
            end
          end
          S_GAP: begin
            if (gcnt == GLAST) begin
              state   <= S_IDLE;
              tx_busy <= 1'b0;
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
